// File: rtl/imem_fetch_rsp.sv
// Instruction-fetch responder: word-addressed store with side load port, configurable wait
// states, and a fault flag for misaligned or out-of-range PCs.
module imem_fetch_rsp #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned WAIT       = 1,
    parameter logic [31:0] BASE       = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic                  rsp_fault,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0]           mem [DEPTH];
    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic                  rsp_valid_d;
    logic                  accept;
    logic                  load_rsp;
    logic                  sel_req;
    logic [31:0]           addr_sel;
    logic [31:0]           offset;
    logic                  fault;
    logic [DEPTH_LOG2-1:0] word_idx;

    assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid;
        load_rsp    = 1'b0;
        sel_req     = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (WAIT > 0) begin
                        state_d     = ST_WAIT;
                        cnt_d       = WAIT_INIT;
                        rsp_valid_d = 1'b0;
                    end else begin
                        // Zero wait: read straight from the incoming PC on the accept edge.
                        state_d     = ST_RESP;
                        load_rsp    = 1'b1;
                        sel_req     = 1'b1;
                        rsp_valid_d = 1'b1;
                    end
                end else if (state_q == ST_RESP && rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    load_rsp    = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // BASE is word-aligned, so offset[1:0] equals the PC's low bits.
    assign addr_sel = sel_req ? req_addr : addr_q;
    assign offset   = addr_sel - BASE;
    assign fault    = (offset[1:0] != 2'b00) || ((offset[31:2] >> DEPTH_LOG2) != 30'd0);
    assign word_idx = offset[DEPTH_LOG2+1:2];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_instr <= 32'd0;
            rsp_fault <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rsp_valid <= rsp_valid_d;
            if (load_rsp) begin
                rsp_fault <= fault;
                rsp_instr <= fault ? 32'd0 : mem[word_idx];
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_rsp.sv
// Directed bench: one instance with WAIT=1 for latency/fault/backpressure/reset cases,
// one with WAIT=0 for single-cycle throughput.
module tb_imem_fetch_rsp;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
    logic [31:0] req_addr, rsp_instr;
    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_fault0;
    logic [31:0] req_addr0, rsp_instr0;

    int checks = 0;
    int errors = 0;

    imem_fetch_rsp #(.DEPTH_LOG2(8), .WAIT(1), .BASE(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_fault(rsp_fault),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_fetch_rsp #(.DEPTH_LOG2(8), .WAIT(0), .BASE(32'h0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_instr(rsp_instr0),
        .rsp_fault(rsp_fault0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    // One fetch on the WAIT=1 instance; lat counts edges from the accept edge to rsp_valid.
    task automatic run_txn(input logic [31:0] addr, output logic [31:0] instr,
                           output logic fault, output int lat);
        bit acc = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        instr = rsp_instr;
        fault = rsp_fault;
    endtask

    logic [31:0] got_instr;
    logic        got_fault;
    int          lat;
    int          seen;

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h2008_0005, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h2009_000A, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0109_5020, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'hAC0A_0000, 1'b0};
        vecs[4] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

        rst = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        check("reset_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_req_ready_w0", {31'd0, req_ready0}, 32'd1);

        load_word(8'd0, 32'h2008_0005);
        load_word(8'd1, 32'h2009_000A);
        load_word(8'd2, 32'h0109_5020);
        load_word(8'd3, 32'hAC0A_0000);

        // Table: latency WAIT+1 = 2, data or fault.
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].addr, got_instr, got_fault, lat);
            check($sformatf("vec%0d_instr", i), got_instr, vecs[i].instr);
            check($sformatf("vec%0d_fault", i), {31'd0, got_fault}, {31'd0, vecs[i].fault});
            check($sformatf("vec%0d_latency", i), lat, 32'd2);
        end
        @(posedge clk);
        #1;
        check("idle_after_table", {31'd0, rsp_valid}, 32'd0);

        // WAIT=0 streaming: one response per cycle, req_ready held high.
        rsp_ready0 = 1'b1;
        req_valid0 = 1'b1;
        req_addr0  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("w0_req_ready%0d", i), {31'd0, req_ready0}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("w0_valid%0d", i), {31'd0, rsp_valid0}, 32'd1);
            check($sformatf("w0_instr%0d", i), rsp_instr0, vecs[i].instr);
            req_addr0 = 32'(4 * (i + 1));
            if (i == 2) req_valid0 = 1'b0;
        end
        @(posedge clk);
        #1;
        check("w0_drain", {31'd0, rsp_valid0}, 32'd0);

        // Backpressure on the WAIT=1 instance.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_instr", rsp_instr, 32'h2009_000A);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp_hold_instr%0d", i), rsp_instr, 32'h2009_000A);
            check($sformatf("bp_hold_ready%0d", i), {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'hC;
        #1;
        check("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("b2b_wait_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("b2b_valid", {31'd0, rsp_valid}, 32'd1);
        check("b2b_instr", rsp_instr, 32'hAC0A_0000);
        @(posedge clk);
        #1;

        // Load to word 2 on the edge that registers the response: old data returned.
        req_valid = 1'b1;
        req_addr  = 32'h8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        load_en   = 1'b1;
        load_addr = 8'd2;
        load_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 load_en = 1'b0;
        check("collide_valid", {31'd0, rsp_valid}, 32'd1);
        check("collide_old", rsp_instr, 32'h0109_5020);
        run_txn(32'h8, got_instr, got_fault, lat);
        check("collide_new", got_instr, 32'hDEAD_BEEF);

        // Reset while in WAIT drops the request entirely.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_wait_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_wait_instr", rsp_instr, 32'd0);
        check("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("rst_no_rsp", seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
